// File: rtl/mole_round_scheduler.sv
// Whack-a-mole game sequencer: alternates an off gap and an on window on one shared
// down-count timer, picks a pseudo-random mole per round and keeps score.
module mole_round_scheduler #(
    parameter int NUM_MOLES = 4,
    parameter int TIMER_W   = 11,
    parameter int OFF_TIME  = 1500,
    parameter int ON_TIME   = 1000,
    parameter int ROUNDS    = 16,
    parameter int SCORE_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] hit,
    input  logic [TIMER_W-1:0]   timer_value,
    output logic                 timer_reset,
    output logic                 timer_up,
    output logic                 timer_enable,
    output logic [TIMER_W-1:0]   timer_start,
    output logic [NUM_MOLES-1:0] led,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           round,
    output logic                 game_over
);
    localparam int SEL_W = $clog2(NUM_MOLES);
    localparam logic [TIMER_W-1:0]   OFF_LD    = TIMER_W'(OFF_TIME);
    localparam logic [TIMER_W-1:0]   ON_LD     = TIMER_W'(ON_TIME);
    localparam logic [7:0]           ROUNDS_V  = 8'(ROUNDS);
    localparam logic [SCORE_W-1:0]   SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [NUM_MOLES-1:0] LED_ONE   = NUM_MOLES'(1);

    typedef enum logic [2:0] {
        IDLE, OFF_LOAD, OFF_WAIT, ON_LOAD, ON_WAIT, ROUND_END, DONE
    } state_t;

    state_t           state_r;
    logic [7:0]       lfsr_r;
    logic [SEL_W-1:0] sel_r;
    logic [SEL_W-1:0] prev_sel_r;
    logic [SEL_W-1:0] raw_s;
    logic [SEL_W-1:0] pick_s;
    logic             fb_s;

    assign timer_up = 1'b0;
    // x^8+x^6+x^5+x^4+1 taps on a left-shifting register
    assign fb_s  = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];
    assign raw_s = lfsr_r[SEL_W-1:0];

    // Next mole: never repeat the previous round's mole
    always_comb begin
        pick_s = raw_s;
        if (raw_s == prev_sel_r) begin
            pick_s = raw_s + SEL_W'(1);
        end else begin
            pick_s = raw_s;
        end
    end

    // Game sequencer with registered timer controls, LED and scoreboard
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            lfsr_r       <= 8'hA5;
            sel_r        <= {SEL_W{1'b0}};
            prev_sel_r   <= {SEL_W{1'b0}};
            timer_reset  <= 1'b1;
            timer_enable <= 1'b0;
            timer_start  <= {TIMER_W{1'b0}};
            led          <= {NUM_MOLES{1'b0}};
            score        <= {SCORE_W{1'b0}};
            round        <= 8'd0;
            game_over    <= 1'b0;
        end else begin
            lfsr_r <= {lfsr_r[6:0], fb_s};
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r      <= OFF_LOAD;
                        score        <= {SCORE_W{1'b0}};
                        round        <= 8'd0;
                        game_over    <= 1'b0;
                        timer_reset  <= 1'b1;
                        timer_start  <= OFF_LD;
                        timer_enable <= 1'b0;
                        led          <= {NUM_MOLES{1'b0}};
                    end
                end
                OFF_LOAD: begin
                    state_r      <= OFF_WAIT;
                    timer_reset  <= 1'b0;
                    timer_enable <= 1'b1;
                end
                OFF_WAIT: begin
                    if (timer_value == {TIMER_W{1'b0}}) begin
                        state_r      <= ON_LOAD;
                        sel_r        <= pick_s;
                        timer_reset  <= 1'b1;
                        timer_start  <= ON_LD;
                        timer_enable <= 1'b0;
                        led          <= LED_ONE << pick_s;
                    end
                end
                ON_LOAD: begin
                    state_r      <= ON_WAIT;
                    timer_reset  <= 1'b0;
                    timer_enable <= 1'b1;
                end
                ON_WAIT: begin
                    // A hit beats a simultaneous expiry
                    if (hit[sel_r] || (timer_value == {TIMER_W{1'b0}})) begin
                        if (hit[sel_r] && (score != SCORE_MAX)) begin
                            score <= score + SCORE_W'(1);
                        end
                        state_r      <= ROUND_END;
                        round        <= round + 8'd1;
                        prev_sel_r   <= sel_r;
                        timer_enable <= 1'b0;
                        led          <= {NUM_MOLES{1'b0}};
                    end
                end
                ROUND_END: begin
                    timer_reset <= 1'b1;
                    if (round == ROUNDS_V) begin
                        state_r     <= DONE;
                        game_over   <= 1'b1;
                        timer_start <= {TIMER_W{1'b0}};
                    end else begin
                        state_r     <= OFF_LOAD;
                        timer_start <= OFF_LD;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    timer_reset  <= 1'b1;
                    timer_enable <= 1'b0;
                    led          <= {NUM_MOLES{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler: behavioural timer, phase-duration game model,
// per-cycle compare plus pinned literal expectations.
module tb_mole_round_scheduler;
    localparam int NM = 4, TW = 11, OFF_T = 3, ON_T = 5, RND = 2;
    localparam int P_IDLE = 0, P_OFF_LOAD = 1, P_OFF_WAIT = 2, P_ON_LOAD = 3,
                   P_ON_WAIT = 4, P_ROUND_END = 5, P_DONE = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, start = 1'b0;
    logic [NM-1:0] hit = '0;
    logic [TW-1:0] tv = '0, tv_s = '0;
    logic          t_rst, t_up, t_en, t_rst_s, t_up_s, t_en_s;
    logic [TW-1:0] t_start, t_start_s;
    logic [NM-1:0] led, led_s;
    logic [7:0]    score, round, round_s;
    logic [0:0]    score_s;
    logic          over, over_s;

    mole_round_scheduler #(.NUM_MOLES(NM), .TIMER_W(TW), .OFF_TIME(OFF_T), .ON_TIME(ON_T),
                           .ROUNDS(RND), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .timer_value(tv),
        .timer_reset(t_rst), .timer_up(t_up), .timer_enable(t_en), .timer_start(t_start),
        .led(led), .score(score), .round(round), .game_over(over));

    mole_round_scheduler #(.NUM_MOLES(NM), .TIMER_W(TW), .OFF_TIME(OFF_T), .ON_TIME(ON_T),
                           .ROUNDS(RND), .SCORE_W(1)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .timer_value(tv_s),
        .timer_reset(t_rst_s), .timer_up(t_up_s), .timer_enable(t_en_s), .timer_start(t_start_s),
        .led(led_s), .score(score_s), .round(round_s), .game_over(over_s));

    // Shared down-counter model, one per instance
    always @(posedge clk) begin
        if (t_rst) tv <= t_start;
        else if (t_en && tv != '0) tv <= tv - 1'b1;
        if (t_rst_s) tv_s <= t_start_s;
        else if (t_en_s && tv_s != '0) tv_s <= tv_s - 1'b1;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Game model: phases with durations derived from OFF_TIME/ON_TIME
    int         ph = P_IDLE, left = 0, m_score = 0, m_round = 0;
    logic [1:0] m_sel = 2'd0, m_prev = 2'd0;
    logic [7:0] m_lfsr = 8'hA5;
    bit         m_over = 1'b0, armed = 1'b0;

    always @(posedge clk) begin : ref_model
        int nph, nleft, nscore, nround;
        logic [1:0] nsel, nprev;
        bit nover, ends;
        if (reset) begin
            ph <= P_IDLE; left <= 0; m_score <= 0; m_round <= 0;
            m_prev <= 2'd0; m_lfsr <= 8'hA5; m_over <= 1'b0; armed <= 1'b1;
        end else if (armed) begin
            nph = ph; nleft = left; nscore = m_score; nround = m_round;
            nsel = m_sel; nprev = m_prev; nover = m_over; ends = 1'b0;
            case (ph)
                P_IDLE, P_DONE:
                    if (start) begin nscore = 0; nround = 0; nover = 1'b0; nph = P_OFF_LOAD; end
                P_OFF_LOAD: begin nph = P_OFF_WAIT; nleft = OFF_T + 1; end
                P_OFF_WAIT:
                    if (nleft == 1) begin
                        nsel = m_lfsr[1:0];
                        if (nsel == m_prev) nsel = nsel + 2'd1;
                        nph = P_ON_LOAD;
                    end else nleft--;
                P_ON_LOAD: begin nph = P_ON_WAIT; nleft = ON_T + 1; end
                P_ON_WAIT: begin
                    if (hit[m_sel]) begin
                        if (nscore < 255) nscore++;
                        ends = 1'b1;
                    end else if (nleft == 1) ends = 1'b1;
                    else nleft--;
                    if (ends) begin nround++; nprev = m_sel; nph = P_ROUND_END; end
                end
                P_ROUND_END:
                    if (m_round == RND) begin nph = P_DONE; nover = 1'b1; end
                    else nph = P_OFF_LOAD;
                default: nph = P_IDLE;
            endcase
            ph <= nph; left <= nleft; m_score <= nscore; m_round <= nround;
            m_sel <= nsel; m_prev <= nprev; m_over <= nover; m_lfsr <= lfsr_next(m_lfsr);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            logic [NM-1:0] e_led;
            bit e_rst, e_en;
            e_led = (ph == P_ON_LOAD || ph == P_ON_WAIT) ? (4'b0001 << m_sel) : 4'b0000;
            e_rst = (ph == P_IDLE || ph == P_OFF_LOAD || ph == P_ON_LOAD || ph == P_DONE);
            e_en  = (ph == P_OFF_WAIT || ph == P_ON_WAIT);
            chk("led", 32'(led), 32'(e_led));
            chk("timer_reset", 32'(t_rst), 32'(e_rst));
            chk("timer_enable", 32'(t_en), 32'(e_en));
            chk("timer_up", 32'(t_up), 32'd0);
            chk("score", 32'(score), 32'(m_score));
            chk("round", 32'(round), 32'(m_round));
            chk("game_over", 32'(over), 32'(m_over));
            if (ph == P_OFF_LOAD) chk("timer_start_off", 32'(t_start), 32'(OFF_T));
            if (ph == P_ON_LOAD)  chk("timer_start_on", 32'(t_start), 32'(ON_T));
            chk("sat_led", 32'(led_s), 32'(e_led));
            chk("sat_score", 32'(score_s), (m_score > 0) ? 32'd1 : 32'd0);
            chk("sat_round", 32'(round_s), 32'(m_round));
            chk("sat_over", 32'(over_s), 32'(m_over));
            chk("sat_ctrl", 32'({t_rst_s, t_en_s, t_up_s}), 32'({e_rst, e_en, 1'b0}));
        end
    end

    int runs[$];
    logic [NM-1:0] lits[$];

    // mode 0: no hits, 1: hit[sel] 2 cycles into ON_WAIT, 2: wrong bits then hit at expiry, 3: random
    task automatic run_game(input int mode);
        int run = 0, cyc = 0;
        logic [NM-1:0] last = '0;
        runs.delete(); lits.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_clears_score", 32'(score), 32'd0);
        chk("start_clears_round", 32'(round), 32'd0);
        chk("start_clears_over", 32'(over), 32'd0);
        while (ph != P_DONE && cyc < 300) begin
            hit = '0;
            if (mode == 3) start = ($urandom_range(0, 7) == 0);
            if (ph == P_ON_WAIT) begin
                case (mode)
                    1: if (ON_T + 1 - left == 2) hit = 4'b0001 << m_sel;
                    2: if (m_round == 0) hit = ~(4'b0001 << m_sel);
                       else if (left == 1) begin
                           hit = 4'b0001 << m_sel;
                           chk("expiry_same_cycle_tv", 32'(tv), 32'd0);
                       end
                    3: if ($urandom_range(0, 2) == 0) hit = 4'($urandom_range(0, 15));
                    default: hit = '0;
                endcase
            end
            if (led != '0) begin run++; last = led; end
            else if (run != 0) begin runs.push_back(run); lits.push_back(last); run = 0; end
            @(negedge clk);
            cyc++;
        end
        hit = '0; start = 1'b0;
        if (cyc >= 300) begin
            n_vec++; n_err++;
            $display("FAIL game_timeout: no DONE after %0d cycles", cyc);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_timer_reset", 32'(t_rst), 32'd1);
        chk("rst_timer_start", 32'(t_start), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_enable", 32'(t_en), 32'd0);
        chk("idle_score", 32'(score), 32'd0);
        chk("idle_over", 32'(over), 32'd0);

        run_game(0);
        chk("nohit_rounds_lit", 32'(runs.size()), 32'd2);
        if (runs.size() == 2) begin
            chk("lit_cycles_r0", 32'(runs[0]), 32'(ON_T + 2));
            chk("lit_cycles_r1", 32'(runs[1]), 32'(ON_T + 2));
            chk("sel_differ", 32'(lits[0] != lits[1]), 32'd1);
            chk("led_onehot", 32'($onehot(lits[0]) && $onehot(lits[1])), 32'd1);
        end
        chk("nohit_score", 32'(score), 32'd0);
        chk("nohit_round", 32'(round), 32'd2);
        chk("nohit_over", 32'(over), 32'd1);

        run_game(1);
        chk("hit_score", 32'(score), 32'd2);
        chk("hit_round", 32'(round), 32'd2);
        chk("sat_score_final", 32'(score_s), 32'd1);

        run_game(2);
        chk("wrongbit_expiry_score", 32'(score), 32'd1);

        // start ignored in ON_WAIT, then reset mid window
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && ph != P_ON_WAIT; i++) @(negedge clk);
        chk("reached_on_wait", 32'(ph), 32'(P_ON_WAIT));
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_ignored_led", 32'(led != '0), 32'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midgame_reset_led", 32'(led), 32'd0);
        chk("midgame_reset_score", 32'(score), 32'd0);

        for (int g = 0; g < 8; g++) run_game(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
